// File: rtl/isq_bank_if.sv
// Handshake bundle for isq_bank: allocate, wake, issue, flush and occupancy status.
// The queue connects through the slave modport; the environment drives it through master.
interface isq_bank_if #(
    parameter int INST_WIDTH = 14,
    parameter int DEPTH      = 8,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
);
    logic                  fls;
    logic                  alloc_vld;
    logic [INST_WIDTH-1:0] alloc_inst;
    logic                  alloc_wat;
    logic                  alloc_rdy;
    logic [DEPTH-1:0]      wake;
    logic                  iss_rdy;
    logic                  iss_vld;
    logic [INST_WIDTH-1:0] iss_inst;
    logic [IDX_WIDTH-1:0]  iss_idx;
    logic [IDX_WIDTH:0]    cnt;
    logic                  full;
    logic                  empty;

    modport master (
        output fls, alloc_vld, alloc_inst, alloc_wat, wake, iss_rdy,
        input  alloc_rdy, iss_vld, iss_inst, iss_idx, cnt, full, empty
    );

    modport slave (
        input  fls, alloc_vld, alloc_inst, alloc_wat, wake, iss_rdy,
        output alloc_rdy, iss_vld, iss_inst, iss_idx, cnt, full, empty
    );
endinterface

// File: rtl/isq_bank.sv
// Issue-queue bank: lines are allocated into the lowest free slot, woken per line,
// and the lowest-index ready line is presented for issue with zero latency.
module isq_bank #(
    parameter int INST_WIDTH = 14,
    parameter int DEPTH      = 8,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    isq_bank_if.slave  bus
);
    localparam logic [IDX_WIDTH:0] FULL_CNT = (IDX_WIDTH+1)'(DEPTH);

    logic [DEPTH-1:0]      val_q;
    logic [DEPTH-1:0]      wat_q;
    logic [INST_WIDTH-1:0] inst_q [DEPTH];
    logic [IDX_WIDTH:0]    cnt_q;

    logic                  full;
    logic                  iss_vld;
    logic [IDX_WIDTH-1:0]  iss_sel;
    logic                  alloc_found;
    logic [IDX_WIDTH-1:0]  alloc_sel;
    logic                  alloc_fire;
    logic                  iss_fire;

    // Both pickers look only at registered val, so an allocation can never land
    // on the line that is issuing in the same cycle.
    always_comb begin
        iss_vld     = 1'b0;
        iss_sel     = '0;
        alloc_found = 1'b0;
        alloc_sel   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!iss_vld && val_q[i] && !wat_q[i]) begin
                iss_vld = 1'b1;
                iss_sel = IDX_WIDTH'(i);
            end
            if (!alloc_found && !val_q[i]) begin
                alloc_found = 1'b1;
                alloc_sel   = IDX_WIDTH'(i);
            end
        end
    end

    assign full       = (cnt_q == FULL_CNT);
    assign alloc_fire = bus.alloc_vld && !full;
    assign iss_fire   = iss_vld && bus.iss_rdy;

    assign bus.alloc_rdy = !full;
    assign bus.iss_vld   = iss_vld;
    assign bus.iss_idx   = iss_sel;
    assign bus.iss_inst  = iss_vld ? inst_q[iss_sel] : '0;
    assign bus.cnt       = cnt_q;
    assign bus.full      = full;
    assign bus.empty     = (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            wat_q <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
            end
        end else if (bus.fls) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (alloc_fire && (alloc_sel == IDX_WIDTH'(i))) begin
                    val_q[i]  <= 1'b1;
                    wat_q[i]  <= bus.alloc_wat;
                    inst_q[i] <= bus.alloc_inst;
                end else begin
                    if (iss_fire && (iss_sel == IDX_WIDTH'(i))) begin
                        val_q[i] <= 1'b0;
                    end
                    if (bus.wake[i] && val_q[i]) begin
                        wat_q[i] <= 1'b0;
                    end
                end
            end
            if (alloc_fire && !iss_fire) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (iss_fire && !alloc_fire) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_isq_bank.sv
// Directed bench for isq_bank (DEPTH=4, INST_WIDTH=14) with hand-computed expectations.
module tb_isq_bank;
    localparam int IW = 14;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    isq_bank_if #(.INST_WIDTH(IW), .DEPTH(DP)) bus ();

    isq_bank #(.INST_WIDTH(IW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".alloc_rdy"}, 32'(bus.alloc_rdy), 32'd1);
        check({tag, ".iss_vld"},   32'(bus.iss_vld),   32'd0);
        check({tag, ".iss_inst"},  32'(bus.iss_inst),  32'd0);
        check({tag, ".iss_idx"},   32'(bus.iss_idx),   32'd0);
        check({tag, ".cnt"},       32'(bus.cnt),       32'd0);
        check({tag, ".full"},      32'(bus.full),      32'd0);
        check({tag, ".empty"},     32'(bus.empty),     32'd1);
    endtask

    task automatic alloc(input logic [IW-1:0] inst, input logic wat);
        bus.alloc_vld  = 1'b1;
        bus.alloc_inst = inst;
        bus.alloc_wat  = wat;
        step();
        bus.alloc_vld  = 1'b0;
    endtask

    initial begin
        bus.fls        = 1'b0;
        bus.alloc_vld  = 1'b0;
        bus.alloc_inst = '0;
        bus.alloc_wat  = 1'b0;
        bus.wake       = '0;
        bus.iss_rdy    = 1'b0;
        #2;
        check_reset_outputs("rst0");
        #1 rst = 1'b0;
        step();

        // single ready allocation issues the next cycle
        alloc(14'h3bab, 1'b0);
        check("a1.iss_vld",  32'(bus.iss_vld),  32'd1);
        check("a1.iss_idx",  32'(bus.iss_idx),  32'd0);
        check("a1.iss_inst", 32'(bus.iss_inst), 32'h3bab);
        check("a1.cnt",      32'(bus.cnt),      32'd1);
        bus.iss_rdy = 1'b1;
        step();
        bus.iss_rdy = 1'b0;
        check("a1.empty",    32'(bus.empty),    32'd1);
        check("a1.cnt0",     32'(bus.cnt),      32'd0);

        // fill with waiting lines, then over-allocate
        for (int k = 0; k < 4; k++) alloc(IW'(14'h100 + k), 1'b1);
        check("fill.full",      32'(bus.full),      32'd1);
        check("fill.alloc_rdy", 32'(bus.alloc_rdy), 32'd0);
        check("fill.iss_vld",   32'(bus.iss_vld),   32'd0);
        alloc(14'h1ff, 1'b0);
        check("fill.cnt_hold",  32'(bus.cnt),       32'd4);

        // wake lines 1 and 3, issue lowest first
        bus.wake = 4'b1010;
        step();
        bus.wake = '0;
        check("wk.idx",  32'(bus.iss_idx),  32'd1);
        check("wk.inst", 32'(bus.iss_inst), 32'h101);
        check("wk.cnt",  32'(bus.cnt),      32'd4);
        bus.iss_rdy = 1'b1;
        step();
        check("wk.idx3", 32'(bus.iss_idx),  32'd3);
        check("wk.ins3", 32'(bus.iss_inst), 32'h103);
        check("wk.cnt3", 32'(bus.cnt),      32'd3);
        step();
        bus.iss_rdy = 1'b0;
        check("wk.cnt2", 32'(bus.cnt),      32'd2);
        check("wk.none", 32'(bus.iss_vld),  32'd0);

        // refill: line 1 ready, line 3 waiting
        alloc(14'h201, 1'b0);
        alloc(14'h203, 1'b1);
        check("rf.full", 32'(bus.full), 32'd1);

        // alloc while full and issuing: alloc ignored, then lands in freed line 1
        bus.alloc_vld  = 1'b1;
        bus.alloc_inst = 14'h2aa;
        bus.alloc_wat  = 1'b0;
        bus.iss_rdy    = 1'b1;
        step();
        bus.iss_rdy = 1'b0;
        check("fi.cnt",       32'(bus.cnt),       32'd3);
        check("fi.alloc_rdy", 32'(bus.alloc_rdy), 32'd1);
        check("fi.iss_vld",   32'(bus.iss_vld),   32'd0);
        step();
        bus.alloc_vld = 1'b0;
        check("fi.cnt4", 32'(bus.cnt),      32'd4);
        check("fi.idx",  32'(bus.iss_idx),  32'd1);
        check("fi.inst", 32'(bus.iss_inst), 32'h2aa);

        // bring cnt to 3, then flush overrides everything
        bus.iss_rdy = 1'b1;
        step();
        check("fl.cnt3", 32'(bus.cnt), 32'd3);
        bus.fls       = 1'b1;
        bus.alloc_vld = 1'b1;
        bus.wake      = 4'hf;
        step();
        bus.fls = 1'b0; bus.alloc_vld = 1'b0; bus.wake = '0; bus.iss_rdy = 1'b0;
        check("fl.cnt",     32'(bus.cnt),     32'd0);
        check("fl.empty",   32'(bus.empty),   32'd1);
        check("fl.iss_vld", 32'(bus.iss_vld), 32'd0);

        // allocation beats same-cycle wake on the target line
        bus.wake = 4'b0001;
        alloc(14'h055, 1'b1);
        bus.wake = '0;
        check("ov.iss_vld", 32'(bus.iss_vld), 32'd0);
        check("ov.cnt",     32'(bus.cnt),     32'd1);
        bus.wake = 4'b0001;
        step();
        bus.wake = '0;
        check("ov.inst", 32'(bus.iss_inst), 32'h055);

        // async reset between edges with two lines held
        alloc(14'h066, 1'b0);
        check("ar.cnt2", 32'(bus.cnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("ar");
        rst = 1'b0;
        alloc(14'h077, 1'b0);
        check("ar.inst", 32'(bus.iss_inst), 32'h077);
        check("ar.idx",  32'(bus.iss_idx),  32'd0);
        check("ar.cnt",  32'(bus.cnt),      32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
